// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file access controller.
//   DEF_DATA_W / DEF_ADDR_W : default data and index widths
//   state_t                 : controller FSM states
//   RF_WRITE / RF_READ      : encoding of the register-file ReadEnable line
package regfile_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;
   localparam logic RF_WRITE = 1'b0;
   localparam logic RF_READ  = 1'b1;
endpackage

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences client write / dual-read requests onto the register-file port.
//   clk, rst_n                : clock, synchronous active-low reset
//   req_*_i / req_ready_o     : request channel (write or dual read)
//   rsp_*                     : read response channel with held data
//   rf_*_o / rf_out1/2_i      : register-file port (ReadEnable, in, RegisterNum1/2, out1/2)
// Optional macro REGFILE_ZERO_REG_EN: register 0 reads as zero and writes to it are dropped.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr1_i,
   input  logic [ADDR_W-1:0] req_addr2_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data1_o,
   output logic [DATA_W-1:0] rsp_data2_o,
   output logic              rf_read_enable_o,
   output logic [DATA_W-1:0] rf_in_o,
   output logic [ADDR_W-1:0] rf_reg_num1_o,
   output logic [ADDR_W-1:0] rf_reg_num2_o,
   input  logic [DATA_W-1:0] rf_out1_i,
   input  logic [DATA_W-1:0] rf_out2_i
);
   state_t              state_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data1_q, rsp_data2_q, rf_in_q;
   logic [ADDR_W-1:0]   rf_reg_num1_q, rf_reg_num2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rsp_valid_q   <= 1'b0;
         rsp_data1_q   <= '0;
         rsp_data2_q   <= '0;
         rf_in_q       <= '0;
         rf_reg_num1_q <= '0;
         rf_reg_num2_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_valid_i) begin
               rf_reg_num1_q <= req_addr1_i;
               rf_reg_num2_q <= req_addr2_i;
               rf_in_q       <= req_wdata_i;
`ifdef REGFILE_ZERO_REG_EN
               state_q <= !req_write_i ? READ : (req_addr1_i == '0) ? IDLE : WRITE;
`else
               state_q <= req_write_i ? WRITE : READ;
`endif
            end
            WRITE:   state_q <= IDLE;
            READ:    state_q <= CAPTURE;
            CAPTURE: begin
`ifdef REGFILE_ZERO_REG_EN
               rsp_data1_q <= (rf_reg_num1_q == '0) ? '0 : rf_out1_i;
               rsp_data2_q <= (rf_reg_num2_q == '0) ? '0 : rf_out2_i;
`else
               rsp_data1_q <= rf_out1_i;
               rsp_data2_q <= rf_out2_i;
`endif
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (rsp_ready_i) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset gates the write strobe combinationally so a reset during WRITE never commits.
   assign rf_read_enable_o = (state_q == WRITE && rst_n) ? RF_WRITE : RF_READ;
   assign req_ready_o      = (state_q == IDLE);
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_data1_o      = rsp_data1_q;
   assign rsp_data2_o      = rsp_data2_q;
   assign rf_in_o          = rf_in_q;
   assign rf_reg_num1_o    = rf_reg_num1_q;
   assign rf_reg_num2_o    = rf_reg_num2_q;
endmodule
